// File: rtl/bus_pkg.sv
// Shared definitions for the drisc bus peripherals: bus access sizes,
// UART transmitter register map, STATUS bit layout and TX state encoding.
package bus_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10
  } data_size_e;

  // Word offsets inside the 16-byte register window (addr[3:2]).
  localparam logic [1:0] REG_TXDATA  = 2'd0;
  localparam logic [1:0] REG_STATUS  = 2'd1;
  localparam logic [1:0] REG_DIVISOR = 2'd2;

  // STATUS bit positions.
  localparam int STAT_FULL      = 0;
  localparam int STAT_EMPTY     = 1;
  localparam int STAT_BUSY      = 2;
  localparam int STAT_OVERFLOW  = 3;
  localparam int STAT_COUNT_LSB = 8;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock circular FIFO with wrapping pointers and an occupancy count.
// A push while full is accepted only when a pop frees a slot in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           push_data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           pop_data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  assign full_o     = (count_q == CW'(DEPTH));
  assign empty_o    = (count_q == '0);
  assign count_o    = count_q;
  assign pop_data_o = mem_q[rd_ptr_q];
  assign do_pop     = pop_i & ~empty_o;
  assign do_push    = push_i & (~full_o | do_pop);

  // Storage write.
  // NOTE: the data array has no reset; pointers and count alone decide which entries are valid.
  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  // Pointer and occupancy tracking; power-of-two depth lets pointers wrap naturally.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/bus_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the drisc processor bus.
// The processor pushes bytes into TXDATA; a shifter drains the FIFO onto tx,
// chaining frames back-to-back while data is queued.
module bus_uart_tx
  import bus_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR       = 32'h00fff000,
  parameter int          FIFO_DEPTH      = 16,
  parameter logic [15:0] DEFAULT_DIVISOR = 16'd434
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] address_bus,
  input  logic        write_address,
  input  logic        write,
  input  logic        read,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        data_out_enable,
  output logic        tx,
  output logic        irq_empty
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  // Bus-side registers
  logic [31:0] addr_q;
  logic [15:0] divisor_q;
  logic        overflow_q, overflow_d;

  // Transmit state
  tx_state_e   state_q;
  logic [7:0]  shift_q;
  logic [15:0] div_q;
  logic [15:0] cyc_q;
  logic [2:0]  bit_q;
  logic        tx_q;

  // FIFO interface
  logic          fifo_full, fifo_empty, fifo_pop;
  logic [7:0]    fifo_data;
  logic [CW-1:0] fifo_count;

  logic        hit;
  logic [1:0]  offset;
  logic        wr_txdata, wr_divisor, rd_status;
  logic        busy, bit_end;
  logic [15:0] div_eff;
  logic [31:0] status_word;

  // Access size is irrelevant to this block; every access is treated as a word.
  logic unused_bits;
  assign unused_bits = ^{data_size, data_in[31:16], addr_q[1:0]};

  assign hit        = (addr_q[31:4] == BASE_ADDR[31:4]);
  assign offset     = addr_q[3:2];
  assign wr_txdata  = write & hit & (offset == REG_TXDATA);
  assign wr_divisor = write & hit & (offset == REG_DIVISOR);
  assign rd_status  = read  & hit & (offset == REG_STATUS);

  assign busy      = (state_q != TX_IDLE);
  assign bit_end   = (cyc_q == div_q - 16'd1);
  assign div_eff   = (divisor_q == 16'd0) ? 16'd1 : divisor_q;
  assign fifo_pop  = ~fifo_empty & ((state_q == TX_IDLE) | ((state_q == TX_STOP) & bit_end));
  assign tx        = tx_q;
  assign irq_empty = fifo_empty & ~busy;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock       (clock),
    .reset       (reset),
    .push_i      (wr_txdata),
    .push_data_i (data_in[7:0]),
    .pop_i       (fifo_pop),
    .pop_data_o  (fifo_data),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

  // Sticky overflow: a dropped push sets it, a STATUS read clears it, set wins.
  // NOTE: combinational blocks assign a default first so no path infers a latch.
  always_comb begin
    overflow_d = overflow_q;
    if (rd_status) overflow_d = 1'b0;
    if (wr_txdata & fifo_full & ~fifo_pop) overflow_d = 1'b1;
  end

  // Address latch, divisor register and overflow flag.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      addr_q     <= '0;
      divisor_q  <= DEFAULT_DIVISOR;
      overflow_q <= 1'b0;
    end else begin
      if (write_address) addr_q <= address_bus;
      if (wr_divisor)    divisor_q <= data_in[15:0];
      overflow_q <= overflow_d;
    end
  end

  // STATUS layout and zero-wait-state read mux.
  always_comb begin
    status_word                          = '0;
    status_word[STAT_FULL]               = fifo_full;
    status_word[STAT_EMPTY]              = fifo_empty;
    status_word[STAT_BUSY]               = busy;
    status_word[STAT_OVERFLOW]           = overflow_q;
    status_word[STAT_COUNT_LSB +: CW]    = fifo_count;
    data_out_enable = read & hit;
    data_out        = '0;
    if (data_out_enable) begin
      case (offset)
        REG_STATUS:  data_out = status_word;
        REG_DIVISOR: data_out = {16'd0, divisor_q};
        default:     data_out = '0;
      endcase
    end
  end

  // Frame sequencer: start bit, eight data bits LSB first, stop bit, each div_q cycles.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= TX_IDLE;
      shift_q <= '0;
      div_q   <= 16'd1;
      cyc_q   <= '0;
      bit_q   <= '0;
      tx_q    <= 1'b1;
    end else begin
      case (state_q)
        TX_IDLE: begin
          tx_q <= 1'b1;
          if (!fifo_empty) begin
            shift_q <= fifo_data;
            div_q   <= div_eff;
            cyc_q   <= '0;
            bit_q   <= '0;
            tx_q    <= 1'b0;
            state_q <= TX_START;
          end
        end
        TX_START: begin
          if (bit_end) begin
            cyc_q   <= '0;
            tx_q    <= shift_q[0];
            state_q <= TX_DATA;
          end else begin
            cyc_q <= cyc_q + 16'd1;
          end
        end
        TX_DATA: begin
          if (bit_end) begin
            cyc_q <= '0;
            if (bit_q == 3'd7) begin
              tx_q    <= 1'b1;
              state_q <= TX_STOP;
            end else begin
              shift_q <= {1'b0, shift_q[7:1]};
              tx_q    <= shift_q[1];
              bit_q   <= bit_q + 3'd1;
            end
          end else begin
            cyc_q <= cyc_q + 16'd1;
          end
        end
        TX_STOP: begin
          if (bit_end) begin
            cyc_q <= '0;
            if (!fifo_empty) begin
              shift_q <= fifo_data;
              div_q   <= div_eff;
              bit_q   <= '0;
              tx_q    <= 1'b0;
              state_q <= TX_START;
            end else begin
              tx_q    <= 1'b1;
              state_q <= TX_IDLE;
            end
          end else begin
            cyc_q <= cyc_q + 16'd1;
          end
        end
        default: begin
          tx_q    <= 1'b1;
          state_q <= TX_IDLE;
        end
      endcase
    end
  end

endmodule
